// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Sequences the IF/ID and ID/EX pipeline registers of the 5-stage core.
//   Detects load-use hazards and taken branches resolved in EX, and freezes
//   the front end while a multi-cycle EX operation completes. Keeps two
//   saturating performance counters (stall cycles, taken-branch flushes).
//
// Ports
//   i_clk, i_rst            core clock, synchronous active-high reset
//   i_id_rs1/rs2, i_id_uses_rs1/rs2   source operands of the ID instruction
//   i_ex_mem_read, i_ex_rd  EX instruction is a load, and its destination
//   i_ex_branch_taken       branch/jump in EX resolved taken
//   i_ex_mc_start           EX holds a multi-cycle op (level)
//   i_counters_clear        synchronous clear of both counters
//   o_pc_write_en, o_if_id_write_en, o_if_id_flush, o_clear_pipeline,
//   o_ex_stall, o_mc_done   pipeline control (combinational)
//   o_stall_count, o_flush_count      registered saturating counters
//
// States
//   RUN     | normal issue; branch > multi-cycle > load-use
//   MC_WAIT | multi-cycle op in EX, r_mc_cnt counts remaining stall cycles
module pipeline_hazard_controller #(
    parameter int MC_LATENCY    = 4,
    parameter int CNT_BITS      = 16,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [REG_ADDR_BITS-1:0] i_id_rs1,
    input  logic [REG_ADDR_BITS-1:0] i_id_rs2,
    input  logic                     i_id_uses_rs1,
    input  logic                     i_id_uses_rs2,
    input  logic                     i_ex_mem_read,
    input  logic [REG_ADDR_BITS-1:0] i_ex_rd,
    input  logic                     i_ex_branch_taken,
    input  logic                     i_ex_mc_start,
    input  logic                     i_counters_clear,
    output logic                     o_pc_write_en,
    output logic                     o_if_id_write_en,
    output logic                     o_if_id_flush,
    output logic                     o_clear_pipeline,
    output logic                     o_ex_stall,
    output logic                     o_mc_done,
    output logic [CNT_BITS-1:0]      o_stall_count,
    output logic [CNT_BITS-1:0]      o_flush_count
);

    localparam int MCW = $clog2(MC_LATENCY);
    // The first stall cycle happens in RUN and the done cycle does not stall,
    // so MC_WAIT is entered with MC_LATENCY-2 stall cycles still to go.
    localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_LATENCY - 2);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [MCW-1:0] r_mc_cnt;
    logic [MCW-1:0] w_mc_cnt_nxt;
    logic           w_lu;
    logic           w_flush_evt;

    assign w_lu = i_ex_mem_read && (i_ex_rd != '0) &&
                  ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                   (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_mc_cnt_nxt     = r_mc_cnt;
        o_pc_write_en    = 1'b1;
        o_if_id_write_en = 1'b1;
        o_if_id_flush    = 1'b0;
        o_clear_pipeline = 1'b0;
        o_ex_stall       = 1'b0;
        o_mc_done        = 1'b0;
        w_flush_evt      = 1'b0;

        if (i_rst) begin
            o_pc_write_en    = 1'b0;
            o_if_id_write_en = 1'b0;
            o_if_id_flush    = 1'b1;
            o_clear_pipeline = 1'b1;
            w_state_nxt      = RUN;
            w_mc_cnt_nxt     = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_ex_branch_taken) begin
                        o_if_id_flush    = 1'b1;
                        o_clear_pipeline = 1'b1;
                        w_flush_evt      = 1'b1;
                    end else if (i_ex_mc_start) begin
                        o_pc_write_en    = 1'b0;
                        o_if_id_write_en = 1'b0;
                        o_ex_stall       = 1'b1;
                        w_state_nxt      = MC_WAIT;
                        w_mc_cnt_nxt     = MC_LOAD;
                    end else if (w_lu) begin
                        o_pc_write_en    = 1'b0;
                        o_if_id_write_en = 1'b0;
                        o_clear_pipeline = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // Branch and mc_start are ignored here, including the done cycle.
                    if (r_mc_cnt != '0) begin
                        o_pc_write_en    = 1'b0;
                        o_if_id_write_en = 1'b0;
                        o_ex_stall       = 1'b1;
                        w_mc_cnt_nxt     = r_mc_cnt - 1'b1;
                    end else begin
                        o_mc_done   = 1'b1;
                        w_state_nxt = RUN;
                        if (w_lu) begin
                            o_pc_write_en    = 1'b0;
                            o_if_id_write_en = 1'b0;
                            o_clear_pipeline = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = RUN;
                    w_mc_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_counters_clear) begin
            o_stall_count <= '0;
            o_flush_count <= '0;
        end else begin
            if (!o_pc_write_en && (o_stall_count != CNT_MAX))
                o_stall_count <= o_stall_count + 1'b1;
            if (w_flush_evt && (o_flush_count != CNT_MAX))
                o_flush_count <= o_flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Two instances share stimulus:
// u_dut uses the defaults (MC_LATENCY=4, CNT_BITS=16); u_dut_s uses
// MC_LATENCY=2 and CNT_BITS=4 for the short-op and saturation cases.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       ex_branch_taken, ex_mc_start, counters_clear;

    logic        pc_we, ifid_we, ifid_fl, clr_p, ex_st, mc_dn;
    logic [15:0] st_cnt, fl_cnt;
    logic        s_pc_we, s_ifid_we, s_ifid_fl, s_clr_p, s_ex_st, s_mc_dn;
    logic [3:0]  s_st_cnt, s_fl_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd),
        .i_ex_branch_taken(ex_branch_taken), .i_ex_mc_start(ex_mc_start),
        .i_counters_clear(counters_clear),
        .o_pc_write_en(pc_we), .o_if_id_write_en(ifid_we),
        .o_if_id_flush(ifid_fl), .o_clear_pipeline(clr_p),
        .o_ex_stall(ex_st), .o_mc_done(mc_dn),
        .o_stall_count(st_cnt), .o_flush_count(fl_cnt)
    );

    pipeline_hazard_controller #(.MC_LATENCY(2), .CNT_BITS(4)) u_dut_s (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd),
        .i_ex_branch_taken(ex_branch_taken), .i_ex_mc_start(ex_mc_start),
        .i_counters_clear(counters_clear),
        .o_pc_write_en(s_pc_we), .o_if_id_write_en(s_ifid_we),
        .o_if_id_flush(s_ifid_fl), .o_clear_pipeline(s_clr_p),
        .o_ex_stall(s_ex_st), .o_mc_done(s_mc_dn),
        .o_stall_count(s_st_cnt), .o_flush_count(s_fl_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, land just after the edge, let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mc_start = 1'b0; counters_clear = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_uses_rs2 = 1'b1; id_rs2 = 5'd5;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Reset outputs
        chk("rst_pc_we",   pc_we,   1'b0);
        chk("rst_ifid_we", ifid_we, 1'b0);
        chk("rst_flush",   ifid_fl, 1'b1);
        chk("rst_clr",     clr_p,   1'b1);
        chk("rst_stall",   ex_st,   1'b0);
        chk("rst_done",    mc_dn,   1'b0);

        rst = 1'b0;
        #1;
        chk("run_pc_we",   pc_we,   1'b1);
        chk("run_ifid_we", ifid_we, 1'b1);
        chk("run_clr",     clr_p,   1'b0);
        tick();
        chk("run_st_cnt", st_cnt, 16'd0);
        chk("run_fl_cnt", fl_cnt, 16'd0);

        // Load-use on rs2, one cycle
        set_lu();
        #1;
        chk("lu_pc_we",   pc_we,   1'b0);
        chk("lu_ifid_we", ifid_we, 1'b0);
        chk("lu_clr",     clr_p,   1'b1);
        chk("lu_flush",   ifid_fl, 1'b0);
        chk("lu_stall",   ex_st,   1'b0);
        tick();
        idle_inputs();
        #1;
        chk("lu_after_pc_we", pc_we,  1'b1);
        chk("lu_st_cnt",      st_cnt, 16'd1);

        // ex_rd = x0 never hazards
        set_lu();
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        chk("x0_pc_we", pc_we, 1'b1);
        chk("x0_clr",   clr_p, 1'b0);
        // Matching rs1 that is not used is not a hazard
        idle_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
        #1;
        chk("rs1_unused_pc_we", pc_we, 1'b1);
        id_uses_rs1 = 1'b1;
        #1;
        chk("rs1_used_pc_we", pc_we, 1'b0);
        id_uses_rs1 = 1'b0;
        #1;
        tick();
        chk("x0_st_cnt", st_cnt, 16'd1);
        idle_inputs();

        // Multi-cycle op, MC_LATENCY=4: 3 stall cycles then done.
        // Branch raised mid-op must be ignored by the long instance.
        ex_mc_start = 1'b1;
        #1;
        chk("mc1_stall", ex_st, 1'b1);
        chk("mc1_pc_we", pc_we, 1'b0);
        chk("mc1_done",  mc_dn, 1'b0);
        chk("mc1_s_stall", s_ex_st, 1'b1);
        tick();
        ex_branch_taken = 1'b1;
        #1;
        chk("mc2_stall", ex_st,   1'b1);
        chk("mc2_flush", ifid_fl, 1'b0);
        chk("mc2_s_done", s_mc_dn, 1'b1);
        tick();
        chk("mc3_stall", ex_st, 1'b1);
        chk("mc3_ifid",  ifid_we, 1'b0);
        tick();
        chk("mc4_done",  mc_dn,   1'b1);
        chk("mc4_stall", ex_st,   1'b0);
        chk("mc4_pc_we", pc_we,   1'b1);
        chk("mc4_flush", ifid_fl, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("mc5_done",   mc_dn,  1'b0);
        chk("mc5_stall",  ex_st,  1'b0);
        chk("mc5_pc_we",  pc_we,  1'b1);
        chk("mc5_st_cnt", st_cnt, 16'd4);
        chk("mc5_fl_cnt", fl_cnt, 16'd0);

        // Branch beats multi-cycle and load-use
        set_lu();
        ex_mc_start = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk("br_flush", ifid_fl, 1'b1);
        chk("br_clr",   clr_p,   1'b1);
        chk("br_pc_we", pc_we,   1'b1);
        chk("br_stall", ex_st,   1'b0);
        tick();
        idle_inputs();
        #1;
        chk("br_fl_cnt", fl_cnt, 16'd1);
        chk("br_run_stall", ex_st, 1'b0);
        chk("br_st_cnt", st_cnt, 16'd4);

        // Reset on second MC_WAIT cycle aborts without mc_done
        ex_mc_start = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rmc_pc_we", pc_we,   1'b0);
        chk("rmc_flush", ifid_fl, 1'b1);
        chk("rmc_stall", ex_st,   1'b0);
        chk("rmc_done",  mc_dn,   1'b0);
        tick();
        chk("rmc_done2", mc_dn, 1'b0);
        rst = 1'b0;
        ex_mc_start = 1'b0;
        #1;
        chk("rmc_run_pc_we", pc_we, 1'b1);
        chk("rmc_run_stall", ex_st, 1'b0);
        chk("rmc_run_done",  mc_dn, 1'b0);
        chk("rmc_st_cnt", st_cnt, 16'd0);
        chk("rmc_fl_cnt", fl_cnt, 16'd0);

        // Saturation: 20 load-use stall cycles on a 4-bit counter
        set_lu();
        for (int i = 0; i < 20; i++) tick();
        chk("sat_s_st_cnt", s_st_cnt, 4'd15);
        chk("sat_st_cnt",   st_cnt,   16'd20);
        idle_inputs();
        counters_clear = 1'b1;
        tick();
        counters_clear = 1'b0;
        chk("clr_s_st_cnt", s_st_cnt, 4'd0);
        chk("clr_st_cnt",   st_cnt,   16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the IF/ID and ID/EX pipeline registers of the 5-stage RISC-V core.
- Detects load-use hazards and taken branches resolved in EX, and freezes the front end for multi-cycle EX operations.
- Drives PC/IF-ID write enables, the IF/ID flush and the ID/EX `clear_pipeline` bubble input.
- Keeps two saturating performance counters (stall cycles, flushes).

Parameters:
- MC_LATENCY, 4: total EX cycles of a multi-cycle op; legal range >=2.
- CNT_BITS, 16: width of each performance counter.
- REG_ADDR_BITS, 5: register index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  REG_ADDR_BITS  rs1 of the instruction in ID.
- id_rs2  in  REG_ADDR_BITS  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_ADDR_BITS  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_mc_start  in  1  instruction in EX is a multi-cycle op (level, held while it sits in EX).
- counters_clear  in  1  synchronous clear of both counters.
- pc_write_en  out  1  PC update enable.
- if_id_write_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  load NOP into IF/ID.
- clear_pipeline  out  1  bubble into ID/EX (control fields zeroed, datapath held).
- ex_stall  out  1  freeze ID/EX and the EX stage; EX/MEM receives a bubble.
- mc_done  out  1  pulse on the final cycle of a multi-cycle op.
- stall_count  out  CNT_BITS  cycles with pc_write_en=0 outside reset.
- flush_count  out  CNT_BITS  number of taken-branch flushes.

Behaviour:
- State register: {RUN, MC_WAIT} plus down-counter mc_cnt. Control outputs are combinational from state and inputs; counters are registered.
- While rst=1:
  - pc_write_en=0, if_id_write_en=0, if_id_flush=1, clear_pipeline=1.
  - ex_stall=0, mc_done=0.
  - Next state RUN, mc_cnt=0, both counters 0.
  - A reset taken in MC_WAIT aborts the op with no mc_done.
- Default in RUN with no event: pc_write_en=1, if_id_write_en=1, all others 0.
- Load-use hazard, LU = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Event priority in RUN, single cycle: branch > multi-cycle > load-use.
  - Branch (ex_branch_taken=1): pc_write_en=1, if_id_write_en=1, if_id_flush=1, clear_pipeline=1; flush_count++. Stays in RUN.
  - Multi-cycle (ex_mc_start=1): pc_write_en=0, if_id_write_en=0, ex_stall=1. Next state MC_WAIT, mc_cnt = MC_LATENCY-2.
  - Load-use (LU=1): pc_write_en=0, if_id_write_en=0, clear_pipeline=1 for exactly one cycle. No state change; the hazard clears naturally once the load reaches MEM.
- MC_WAIT:
  - mc_cnt!=0: pc_write_en=0, if_id_write_en=0, ex_stall=1; mc_cnt decrements.
  - mc_cnt==0: mc_done=1, pc_write_en=1, if_id_write_en=1, ex_stall=0, unless LU=1, in which case the load-use outputs apply as well. Next state RUN.
  - ex_branch_taken and ex_mc_start are ignored throughout MC_WAIT, including the done cycle.
- Stall length: a multi-cycle op stalls for exactly MC_LATENCY-1 cycles, counted from its first EX cycle, then leaves EX at the end of the done cycle. With MC_LATENCY=2 this is 1 stall cycle, then the done cycle.
- Counters:
  - Saturate at all-ones; no wrap.
  - counters_clear has priority over increment; the other state machine logic is unaffected.
  - stall_count increments on every cycle with pc_write_en=0 and rst=0.

Test Plan:
- Reset with MC_LATENCY=4 → during rst all four control outputs read 0/0/1/1. Release rst → pc_write_en=1, if_id_write_en=1, counters 0.
- ex_mem_read=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 for 1 cycle → exactly one cycle of pc_write_en=0, if_id_write_en=0, clear_pipeline=1; stall_count=1. Repeating with ex_rd=0 → no stall.
- ex_mc_start held high (MC_LATENCY=4) → ex_stall=1 for 3 cycles, mc_done=1 on the 4th, RUN on the 5th; stall_count=3.
- ex_branch_taken=1 together with LU=1 and ex_mc_start=1 → if_id_flush=1, clear_pipeline=1, pc_write_en=1, ex_stall=0; flush_count=1, state stays RUN.
- rst asserted on the second MC_WAIT cycle → reset outputs, no mc_done. After release, ex_mc_start low gives normal RUN.
- CNT_BITS=4, 20 load-use stalls → stall_count holds at 15. Pulse counters_clear → 0 the next cycle.
